// File: rtl/hid_event_fifo.sv
// hid_event_fifo: per-channel HID event buffers behind a 64-bit bus window.
// Define HID_EVT_TIMESTAMP_EN to store a cycle stamp with every entry.
module hid_event_fifo #(
  parameter int NCH   = 2,
  parameter int DW    = 24,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NCH-1:0]    ev_valid,
  input  logic [NCH*DW-1:0] ev_data,
  input  logic              hid_en,
  input  logic [7:0]        hid_we,
  input  logic [AW-1:0]     hid_addr,
  input  logic [63:0]       hid_wrdata,
  output logic [63:0]       hid_rddata,
  output logic              irq_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = AW - 5;

  logic          bus_wr;
  logic          bus_rd;
  logic [CW-1:0] sel;
  logic [1:0]    rsel;
  logic          sel_ok;

  assign bus_wr = hid_en & (|hid_we);
  assign bus_rd = hid_en & ~(|hid_we);
  assign sel    = hid_addr[AW-1:5];
  assign rsel   = hid_addr[4:3];
  assign sel_ok = (32'(sel) < NCH);

  logic [NCH-1:0] empty;
  logic [NCH-1:0] sticky;
  logic [NCH-1:0] ien;
  logic [DW-1:0]  head    [NCH];
  logic [LW-1:0]  level   [NCH];
  logic [15:0]    ovf_cnt [NCH];
  logic [63:0]    rd_word;

  logic unused;
  assign unused = ^{hid_wrdata[63:2], hid_addr[2:0]};

`ifdef HID_EVT_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] head_ts [NCH];

  // free-running stamp counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) ts_q <= '0;
    else         ts_q <= ts_q + 32'd1;
  end
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] lvl;
    logic [15:0]   cnt;
    logic          stk;
    logic          ien_q;
    logic          hit, pop, flush, clr;
    logic          full, do_pop, do_push, ovf;

    assign hit   = bus_wr && sel_ok && (32'(sel) == c);
    assign pop   = hit && (rsel == 2'd0);
    assign flush = hit && (rsel == 2'd2) && hid_wrdata[0];
    assign clr   = hit && (rsel == 2'd1) && hid_wrdata[0];

    assign full     = (lvl == LW'(DEPTH));
    assign empty[c] = (lvl == '0);

    // pop goes first, so a full buffer can accept a same-cycle push
    assign do_pop  = pop && !empty[c] && !flush;
    assign do_push = ev_valid[c] && !flush && (!full || do_pop);
    assign ovf     = ev_valid[c] && !flush && full && !do_pop;

    // payload storage
    always_ff @(posedge clk_i) begin
      if (rst_ni && do_push) mem[wr_ptr] <= ev_data[c*DW +: DW];
    end

`ifdef HID_EVT_TIMESTAMP_EN
    logic [31:0] tmem [DEPTH];

    // stamp storage, written alongside the payload
    always_ff @(posedge clk_i) begin
      if (rst_ni && do_push) tmem[wr_ptr] <= ts_q;
    end

    assign head_ts[c] = tmem[rd_ptr];
`endif

    // pointers and level
    always_ff @(posedge clk_i) begin
      if (!rst_ni || flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        lvl    <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        lvl <= lvl + LW'(do_push) - LW'(do_pop);
      end
    end

    // overflow count and sticky flag
    always_ff @(posedge clk_i) begin
      if (!rst_ni || clr) begin
        cnt <= '0;
        stk <= 1'b0;
      end else if (ovf) begin
        if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        stk <= 1'b1;
      end
    end

    // interrupt enable
    always_ff @(posedge clk_i) begin
      if (!rst_ni)                   ien_q <= 1'b0;
      else if (hit && rsel == 2'd2)  ien_q <= hid_wrdata[1];
    end

    assign head[c]    = mem[rd_ptr];
    assign level[c]   = lvl;
    assign ovf_cnt[c] = cnt;
    assign sticky[c]  = stk;
    assign ien[c]     = ien_q;
  end

  // register read mux
  always_comb begin
    rd_word = '0;
    if (sel_ok) begin
      case (rsel)
        2'd0: begin
          if (!empty[sel]) begin
            rd_word[DW-1:0] = head[sel];
`ifdef HID_EVT_TIMESTAMP_EN
            rd_word[63:32] = head_ts[sel];
`endif
          end
          rd_word[24] = empty[sel];
          rd_word[25] = sticky[sel];
        end
        2'd1: begin
          rd_word[10:0]  = 11'(level[sel]);
          rd_word[31:16] = ovf_cnt[sel];
        end
        2'd2: rd_word[1] = ien[sel];
        default: ;
      endcase
    end
  end

  // registered read data and interrupt
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hid_rddata <= '0;
      irq_o      <= 1'b0;
    end else begin
      if (bus_rd) hid_rddata <= rd_word;
      irq_o <= |(ien & ~empty);
    end
  end

endmodule

// File: tb/tb_hid_event_fifo.sv
// tb_hid_event_fifo: directed and random checks of hid_event_fifo
// against a queue-based model of the channel buffers.
module tb_hid_event_fifo;
  localparam int NCH   = 2;
  localparam int DW    = 24;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NCH-1:0]    ev_valid = '0;
  logic [NCH*DW-1:0] ev_data = '0;
  logic              hid_en = 1'b0;
  logic [7:0]        hid_we = '0;
  logic [AW-1:0]     hid_addr = '0;
  logic [63:0]       hid_wrdata = '0;
  logic [63:0]       hid_rddata;
  logic              irq_o;

  always #5 clk_i = ~clk_i;

  hid_event_fifo #(
    .NCH(NCH), .DW(DW), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ev_valid(ev_valid), .ev_data(ev_data),
    .hid_en(hid_en), .hid_we(hid_we),
    .hid_addr(hid_addr), .hid_wrdata(hid_wrdata),
    .hid_rddata(hid_rddata), .irq_o(irq_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [55:0] q [NCH][$];
  int          ovf [NCH];
  bit          stk [NCH];
  bit          ien [NCH];
  bit          exp_irq;
  int unsigned cyc;

  function automatic logic [63:0] exp_read(input logic [AW-1:0] a);
    int c;
    int r;
    logic [63:0] w;
    c = int'(a[AW-1:5]);
    r = int'(a[4:3]);
    w = '0;
    if (c >= NCH) return w;
    if (r == 0) begin
      w[24] = (q[c].size() == 0);
      w[25] = stk[c];
      if (q[c].size() > 0) begin
        w[23:0] = q[c][0][23:0];
`ifdef HID_EVT_TIMESTAMP_EN
        w[63:32] = q[c][0][55:24];
`endif
      end
    end else if (r == 1) begin
      w[10:0]  = 11'(q[c].size());
      w[31:16] = 16'(ovf[c]);
    end else if (r == 2) begin
      w[1] = ien[c];
    end
    return w;
  endfunction

  task automatic step(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d,
                      input logic en, input logic [7:0] we,
                      input logic [AW-1:0] a, input logic [63:0] wd);
    bit pre_irq;
    bit wr;
    int c;
    int r;
    ev_valid = v; ev_data = d; hid_en = en;
    hid_we = we; hid_addr = a; hid_wrdata = wd;
    pre_irq = 0;
    for (int i = 0; i < NCH; i++)
      if (ien[i] && q[i].size() > 0) pre_irq = 1;
    @(posedge clk_i);
    wr = en && (we != 0);
    c = int'(a[AW-1:5]);
    r = int'(a[4:3]);
    for (int i = 0; i < NCH; i++) begin
      bit s;
      s = wr && (c == i);
      if (s && r == 2 && wd[0]) begin
        q[i].delete();
      end else begin
        if (s && r == 0 && q[i].size() > 0) void'(q[i].pop_front());
        if (v[i]) begin
          if (q[i].size() < DEPTH) begin
            q[i].push_back({cyc, d[i*DW +: DW]});
          end else begin
            if (ovf[i] < 65535) ovf[i]++;
            stk[i] = 1;
          end
        end
      end
      if (s && r == 1 && wd[0]) begin ovf[i] = 0; stk[i] = 0; end
      if (s && r == 2) ien[i] = wd[1];
    end
    exp_irq = pre_irq;
    cyc++;
    @(negedge clk_i);
    ev_valid = '0; hid_en = 1'b0; hid_we = '0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [63:0] r);
    step('0, '0, 1'b1, 8'h00, a, 64'h0);
    r = hid_rddata;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    ev_valid = '0; hid_en = 1'b0; hid_we = '0;
    @(posedge clk_i);
    for (int i = 0; i < NCH; i++) begin
      q[i].delete(); ovf[i] = 0; stk[i] = 0; ien[i] = 0;
    end
    exp_irq = 0;
    cyc = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    logic [63:0] r;
    do_reset();
    n_cmp++;
    if (hid_rddata !== 64'h0) begin
      n_bad++; $display("FAIL reset_rddata: got %h want 0", hid_rddata);
    end
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_irq: got %b want 0", irq_o);
    end
    bus_read(6'h00, r);
    n_cmp++;
    if (r !== 64'h0000_0000_0100_0000) begin
      n_bad++; $display("FAIL reset_data0: got %h want 0000000001000000", r);
    end
  endtask

  task automatic test_fifo_basic();
    logic [63:0] r;
    logic [63:0] e;
    step(2'b01, 48'h00001C, 1'b0, 8'h00, 6'h00, 64'h0);
    step(2'b01, 48'h0000F0, 1'b0, 8'h00, 6'h00, 64'h0);
    for (int k = 0; k < 3; k++) begin
      bus_read(6'h08, r);
      n_cmp++;
      if (r !== 64'(2 - k)) begin
        n_bad++; $display("FAIL basic_level%0d: got %h want %0d", k, r, 2 - k);
      end
      e = exp_read(6'h00);
      bus_read(6'h00, r);
      n_cmp++;
      if (r !== e) begin
        n_bad++; $display("FAIL basic_data%0d: got %h want %h", k, r, e);
      end
      n_cmp++;
      if (k == 0 && r[25:0] !== 26'h000001C ||
          k == 1 && r[25:0] !== 26'h00000F0 ||
          k == 2 && r[25:0] !== 26'h1000000) begin
        n_bad++; $display("FAIL basic_head%0d: got %h", k, r[25:0]);
      end
      step('0, '0, 1'b1, 8'hFF, 6'h00, 64'h0);
    end
  endtask

  logic [23:0] first1;

  task automatic test_overflow();
    logic [63:0] r;
    logic [23:0] x;
    for (int k = 0; k < DEPTH + 3; k++) begin
      x = 24'($urandom);
      if (k == 0) first1 = x;
      step(2'b10, {x, 24'h0}, 1'b0, 8'h00, 6'h00, 64'h0);
    end
    bus_read(6'h28, r);
    n_cmp++;
    if (r !== 64'h0000_0000_0003_0040) begin
      n_bad++; $display("FAIL ovf_status: got %h want 0000000000030040", r);
    end
    bus_read(6'h20, r);
    n_cmp++;
    if (r[25:0] !== {2'b10, first1}) begin
      n_bad++; $display("FAIL ovf_head: got %h want %h", r[25:0], {2'b10, first1});
    end
  endtask

  task automatic test_full_pushpop();
    logic [63:0] r;
    logic [63:0] e;
    logic [23:0] x;
    x = 24'($urandom);
    step(2'b10, {x, 24'h0}, 1'b1, 8'hFF, 6'h20, 64'h0);
    bus_read(6'h28, r);
    n_cmp++;
    if (r !== 64'h0000_0000_0003_0040) begin
      n_bad++; $display("FAIL fullpp_status: got %h want 0000000000030040", r);
    end
    for (int k = 0; k < DEPTH; k++) begin
      e = exp_read(6'h20);
      bus_read(6'h20, r);
      n_cmp++;
      if (r !== e) begin
        n_bad++; $display("FAIL fullpp_drain%0d: got %h want %h", k, r, e);
      end
      if (k == DEPTH - 1) begin
        n_cmp++;
        if (r[23:0] !== x) begin
          n_bad++; $display("FAIL fullpp_last: got %h want %h", r[23:0], x);
        end
      end
      step('0, '0, 1'b1, 8'h01, 6'h20, 64'h0);
    end
    step('0, '0, 1'b1, 8'h0F, 6'h28, 64'h1);
    bus_read(6'h20, r);
    n_cmp++;
    if (r[25:24] !== 2'b01) begin
      n_bad++; $display("FAIL fullpp_clear: got %b want 01", r[25:24]);
    end
  endtask

  task automatic test_irq();
    logic [63:0] r;
    step('0, '0, 1'b1, 8'hFF, 6'h10, 64'h2);
    step(2'b01, 48'h000055, 1'b0, 8'h00, 6'h00, 64'h0);
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_bad++; $display("FAIL irq_lag: got %b want 0", irq_o);
    end
    step('0, '0, 1'b0, 8'h00, 6'h00, 64'h0);
    n_cmp++;
    if (irq_o !== 1'b1) begin
      n_bad++; $display("FAIL irq_rise: got %b want 1", irq_o);
    end
    step(2'b01, 48'h000077, 1'b1, 8'hFF, 6'h10, 64'h3);
    n_cmp++;
    if (irq_o !== 1'b1) begin
      n_bad++; $display("FAIL irq_hold: got %b want 1", irq_o);
    end
    bus_read(6'h08, r);
    n_cmp++;
    if (r !== 64'h0) begin
      n_bad++; $display("FAIL flush_status: got %h want 0", r);
    end
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_bad++; $display("FAIL irq_fall: got %b want 0", irq_o);
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] v;
    logic [47:0]    d;
    logic [AW-1:0]  a;
    logic [63:0]    e;
    logic [63:0]    wd;
    int             op;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < NCH; i++) v[i] = ($urandom_range(0, 9) < 3);
      d  = {24'($urandom), 24'($urandom)};
      a  = AW'($urandom);
      op = int'($urandom_range(0, 9));
      if (op <= 4) begin
        e = exp_read(a);
        step(v, d, 1'b1, 8'h00, a, 64'h0);
        n_cmp++;
        if (hid_rddata !== e) begin
          n_bad++; $display("FAIL rnd_read@%0d a=%h: got %h want %h", k, a, hid_rddata, e);
        end
      end else if (op <= 7) begin
        step(v, d, 1'b1, 8'($urandom_range(1, 255)), {a[5], 5'b0}, 64'h0);
      end else if (op == 8) begin
        wd = {$urandom, $urandom};
        wd[0] = ($urandom_range(0, 5) == 0);
        a[4:3] = 2'($urandom_range(1, 3));
        step(v, d, 1'b1, 8'h80, a, wd);
      end else begin
        step(v, d, 1'b0, 8'h00, a, 64'h0);
      end
      n_cmp++;
      if (irq_o !== exp_irq) begin
        n_bad++; $display("FAIL rnd_irq@%0d: got %b want %b", k, irq_o, exp_irq);
      end
    end
  endtask

  task automatic test_timestamp();
    logic [63:0] r;
    logic [63:0] e;
    logic [31:0] want;
    do_reset();
    while (cyc < 100) step('0, '0, 1'b0, 8'h00, 6'h00, 64'h0);
    step(2'b01, 48'h000AAA, 1'b0, 8'h00, 6'h00, 64'h0);
    while (cyc < 105) step('0, '0, 1'b0, 8'h00, 6'h00, 64'h0);
    step(2'b01, 48'h000BBB, 1'b0, 8'h00, 6'h00, 64'h0);
    for (int k = 0; k < 2; k++) begin
`ifdef HID_EVT_TIMESTAMP_EN
      want = (k == 0) ? 32'd100 : 32'd105;
`else
      want = 32'd0;
`endif
      e = exp_read(6'h00);
      bus_read(6'h00, r);
      n_cmp++;
      if (r[63:32] !== want) begin
        n_bad++; $display("FAIL ts%0d: got %0d want %0d", k, r[63:32], want);
      end
      n_cmp++;
      if (r !== e) begin
        n_bad++; $display("FAIL ts_word%0d: got %h want %h", k, r, e);
      end
      step('0, '0, 1'b1, 8'hFF, 6'h00, 64'h0);
    end
  endtask

  initial begin
    test_reset();
    test_fifo_basic();
    test_overflow();
    test_full_pushpop();
    test_irq();
    test_random();
    test_timestamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hid_event_fifo.md
Name: hid_event_fifo

Overview:
- Parametrised, multi-channel event buffer for HID sources such as the PS/2 keyboard and the mouse decoder.
- Replaces the per-device vendor FIFO primitives with inferred storage. Channel count, entry width and depth are set by parameters.
- Adds per-channel overflow accounting, flush, interrupt enable and a registered bus read path.
- Sits between the HID decoders and the HID memory-mapped window of the SoC.

Parameters:
- NCH, 2, number of event channels (1..8).
- DW, 24, event payload width in bits (1..24).
- DEPTH, 64, entries per channel; power of two, 2..1024.
- AW, 6, low bus address bits decoded by this block.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_ni  in  1  synchronous active-low reset.
- ev_valid  in  NCH  per-channel push strobe; one entry is pushed per cycle high.
- ev_data  in  NCH*DW  per-channel payload; channel c occupies bits [c*DW +: DW].
- hid_en  in  1  bus access strobe.
- hid_we  in  8  byte write enables; any bit set makes the access a write.
- hid_addr  in  AW  byte address; [4:3] selects register, [AW-1:5] selects channel.
- hid_wrdata  in  64  write data.
- hid_rddata  out  64  registered read data.
- irq_o  out  1  registered interrupt request.

Behaviour:
- Reset (rst_ni low at a clock edge) clears:
  - all pointers and levels;
  - overflow counters and sticky overflow flags;
  - irq enables;
  - hid_rddata to 0 and irq_o to 0.
- Reset is synchronous. If asserted mid-operation, all buffered events are discarded at that edge and any same-cycle push or pop is ignored.
- Storage: NCH independent circular buffers. Pointers wrap modulo DEPTH. The level counter is log2(DEPTH)+1 bits wide.
- Register map per channel, selected by hid_addr[4:3]:
  - 0 DATA. Read returns:
    - [DW-1:0] head entry, zero-extended to bit 23;
    - [24] empty;
    - [25] sticky overflow;
    - [31:26] zero;
    - [63:32] timestamp (see Optional Feature).
    - A write with any byte enable pops one entry. The write data is ignored.
  - 1 STATUS. Read returns [10:0] level and [31:16] overflow count. A write with wrdata[0]=1 clears the overflow count and the sticky flag.
  - 2 CTRL. A write with wrdata[0]=1 flushes the channel. wrdata[1] sets the irq enable and is held. Read returns [1] irq enable.
  - 3 reserved. Reads return 0; writes are ignored.
- Channel select at or above NCH: reads return 0, writes are ignored.
- Read latency: exactly one cycle. hid_rddata updates on the edge after hid_en with hid_we==0 and holds until the next read. A read never pops.
- Push, not full: entry written at the tail, level +1.
- Push while full with no same-cycle pop:
  - the entry is dropped;
  - the overflow count increments, saturating at 16'hFFFF;
  - the sticky flag is set.
- Push and pop in the same cycle:
  - when not full and not empty, level is unchanged;
  - when full, the pop is applied first and the push is accepted (no overflow);
  - when empty, the push is accepted and the pop is ignored (level becomes 1).
- Pop while empty: no effect and no error.
- Flush together with a push in the same cycle: flush wins. The push is discarded and not counted as an overflow; level becomes 0.
- irq_o is registered: the OR over all channels of (irq enable AND not empty), with one cycle lag.

Optional Feature:
- Macro HID_EVT_TIMESTAMP_EN.
- When defined:
  - a 32-bit free-running cycle counter, reset to 0, wraps at 2^32;
  - the counter value at the push edge is stored with each entry;
  - a DATA read returns that stored value in bits [63:32].
- When undefined: no counter or extra storage exists, and bits [63:32] read 0.

Test Plan:
- Reset, then read DATA of channel 0 → hid_rddata = 64'h0000_0000_0100_0000 (empty=1) one cycle after the read. irq_o = 0.
- Push 0x00001C, then 0x0000F0 on channel 0. Read DATA → 0x01C with empty=0. Pop. Read → 0x0F0. Pop. Read → empty=1. STATUS level follows 2,1,0.
- Fill channel 1 with 64 entries, then push 3 more with no pop → STATUS reads 64 in [10:0] and 3 in [31:16]. DATA bit25=1. The head is still the first entry.
- With channel 1 full, apply push and pop in the same cycle → level stays 64, overflow count unchanged, the pushed value appears last after 64 pops.
- Set CTRL irq enable on channel 0, then push one entry → irq_o rises on the second edge after the push. Flush in the same cycle as another push → level 0, overflow 0, irq_o falls one cycle later.
- With HID_EVT_TIMESTAMP_EN defined, push at cycle counts 100 and 105 after reset → DATA [63:32] reads 100, then after a pop reads 105. With the macro undefined, [63:32] reads 0.
